// File: rtl/mask_window_filter.sv
// 3x3 neighbourhood vote filter for the 1-bit segmentation mask.
// Column taps are fed by the current pixel and two line-buffer outputs. Each accepted sample
// completes the window centred one row up and one column left. That window is registered, then
// popcounted and compared against THRESH.
module mask_window_filter #(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter int unsigned COL_WIDTH = 10,
  parameter int unsigned ROW_WIDTH = 10,
  parameter int unsigned THRESH    = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [COL_WIDTH-1:0] col,
  input  logic [ROW_WIDTH-1:0] row,
  input  logic                 px_cur,
  input  logic                 px_up1,
  input  logic                 px_up2,
  output logic                 out_valid,
  output logic [COL_WIDTH-1:0] out_col,
  output logic [ROW_WIDTH-1:0] out_row,
  output logic [3:0]           out_count,
  output logic                 out_px
);

  if (THRESH < 1 || THRESH > 9) begin : g_bad_thresh
    $error("mask_window_filter: THRESH must be in 1..9");
  end

  localparam logic [COL_WIDTH-1:0] ColOne = COL_WIDTH'(1);
  localparam logic [ROW_WIDTH-1:0] RowOne = ROW_WIDTH'(1);

  // Ones in a 9-bit window; the result is at most 9, so it fits in 4 bits.
  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Input qualification
  // ---------------------------------------------------------------------------
  logic w_accept;
  logic w_col_first;
  logic w_emit;
  logic w_border;

  // Out-of-range coordinates are ignored, the same guard the line buffers apply on write.
  always_comb begin
    w_accept    = in_valid && (32'(col) < WIDTH) && (32'(row) < HEIGHT);
    w_col_first = (col == '0);
    w_emit      = w_accept && (row != '0) && (col != '0);
    // The centre lands on row 0 or col 0, so the window hangs off the frame edge.
    w_border    = (row == RowOne) || (col == ColOne);
  end

  // ---------------------------------------------------------------------------
  // Column shift registers: bit 0 = newest column (col), bit 2 = oldest (col-2)
  // ---------------------------------------------------------------------------
  logic [2:0] r_top, r_mid, r_bot;
  logic [2:0] w_top_nxt, w_mid_nxt, w_bot_nxt;

  // Shift on accepted samples; at the start of a line the older taps are cleared.
  always_comb begin
    w_top_nxt = r_top;
    w_mid_nxt = r_mid;
    w_bot_nxt = r_bot;
    if (w_accept) begin
      if (w_col_first) begin
        w_top_nxt = {2'b00, px_up2};
        w_mid_nxt = {2'b00, px_up1};
        w_bot_nxt = {2'b00, px_cur};
      end else begin
        w_top_nxt = {r_top[1:0], px_up2};
        w_mid_nxt = {r_mid[1:0], px_up1};
        w_bot_nxt = {r_bot[1:0], px_cur};
      end
    end
  end

  // Window tap state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_top <= '0;
      r_mid <= '0;
      r_bot <= '0;
    end else begin
      r_top <= w_top_nxt;
      r_mid <= w_mid_nxt;
      r_bot <= w_bot_nxt;
    end
  end

  // Centre coordinates and emit flag travelling alongside the tap update.
  logic                 r_tap_emit;
  logic                 r_tap_border;
  logic [COL_WIDTH-1:0] r_tap_col;
  logic [ROW_WIDTH-1:0] r_tap_row;

  // Capture the centre of the window completed by this sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tap_emit   <= 1'b0;
      r_tap_border <= 1'b0;
      r_tap_col    <= '0;
      r_tap_row    <= '0;
    end else begin
      r_tap_emit <= w_emit;
      if (w_emit) begin
        r_tap_border <= w_border;
        r_tap_col    <= col - ColOne;
        r_tap_row    <= row - RowOne;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: registered window, centre and emit flag
  // ---------------------------------------------------------------------------
  logic                 r_s1_emit;
  logic                 r_s1_border;
  logic [8:0]           r_s1_win;
  logic [COL_WIDTH-1:0] r_s1_col;
  logic [ROW_WIDTH-1:0] r_s1_row;

  // Snapshot the completed window so the taps are free to shift on the next sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_emit   <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_win    <= '0;
      r_s1_col    <= '0;
      r_s1_row    <= '0;
    end else begin
      r_s1_emit <= r_tap_emit;
      if (r_tap_emit) begin
        r_s1_border <= r_tap_border;
        r_s1_win    <= {r_top, r_mid, r_bot};
        r_s1_col    <= r_tap_col;
        r_s1_row    <= r_tap_row;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: vote and output registers
  // ---------------------------------------------------------------------------
  logic [3:0] w_count;
  logic       w_px;

  // Border windows are incomplete and always vote 0.
  always_comb begin
    w_count = r_s1_border ? 4'd0 : popcount9(r_s1_win);
    w_px    = !r_s1_border && (32'(w_count) >= THRESH);
  end

  logic                 r_out_valid;
  logic                 r_out_px;
  logic [3:0]           r_out_count;
  logic [COL_WIDTH-1:0] r_out_col;
  logic [ROW_WIDTH-1:0] r_out_row;

  // Output data updates only on emitted windows and holds through bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_px    <= 1'b0;
      r_out_count <= '0;
      r_out_col   <= '0;
      r_out_row   <= '0;
    end else begin
      r_out_valid <= r_s1_emit;
      if (r_s1_emit) begin
        r_out_px    <= w_px;
        r_out_count <= w_count;
        r_out_col   <= r_s1_col;
        r_out_row   <= r_s1_row;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_px    = r_out_px;
  assign out_count = r_out_count;
  assign out_col   = r_out_col;
  assign out_row   = r_out_row;

endmodule

// File: tb/tb_mask_window_filter.sv
// Self-checking bench for mask_window_filter. Four instances share the same inputs and differ
// only in THRESH. The expected stream comes from an image-based reference: each centre's count
// is summed directly from the frame array.
module tb_mask_window_filter;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 10;
  localparam int RW = 10;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [CW-1:0] col = '0;
  logic [RW-1:0] row = '0;
  logic          px_cur = 1'b0;
  logic          px_up1 = 1'b0;
  logic          px_up2 = 1'b0;

  logic          o_valid [NI];
  logic [CW-1:0] o_col   [NI];
  logic [RW-1:0] o_row   [NI];
  logic [3:0]    o_count [NI];
  logic          o_px    [NI];

  int thr [NI] = '{5, 1, 2, 9};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mask_window_filter #(
      .WIDTH    (W),
      .HEIGHT   (H),
      .COL_WIDTH(CW),
      .ROW_WIDTH(RW),
      .THRESH   ((g == 0) ? 5 : (g == 1) ? 1 : (g == 2) ? 2 : 9)
    ) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .col      (col),
      .row      (row),
      .px_cur   (px_cur),
      .px_up1   (px_up1),
      .px_up2   (px_up2),
      .out_valid(o_valid[g]),
      .out_col  (o_col[g]),
      .out_row  (o_row[g]),
      .out_count(o_count[g]),
      .out_px   (o_px[g])
    );
  end

  typedef struct {
    int          r;
    int          c;
    int          cnt;
    bit [NI-1:0] px;
    longint      due;
  } exp_t;

  exp_t   q[$];
  bit     img [H][W];
  longint cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  int     last_r = 0, last_c = 0, last_cnt = 0;
  bit     last_px [NI];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: count of ones in the 3x3 neighbourhood of a centre; frame-edge centres give 0.
  function automatic int win_count(input int r, input int c);
    int n;
    n = 0;
    if (r == 0 || c == 0) return 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        n += int'(img[r + dr][c + dc]);
    return n;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled just after each rising edge.
  always begin
    bit ev;
    @(posedge clk);
    #1;
    ev = (q.size() > 0) && (q[0].due == cyc);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("valid[%0d]", i), 32'(o_valid[i]), 32'(ev));
      if (ev) begin
        check_eq($sformatf("row[%0d]", i), 32'(o_row[i]), q[0].r);
        check_eq($sformatf("col[%0d]", i), 32'(o_col[i]), q[0].c);
        check_eq($sformatf("count[%0d]", i), 32'(o_count[i]), q[0].cnt);
        check_eq($sformatf("px[%0d]", i), 32'(o_px[i]), 32'(q[0].px[i]));
      end else begin
        check_eq($sformatf("hold_row[%0d]", i), 32'(o_row[i]), last_r);
        check_eq($sformatf("hold_col[%0d]", i), 32'(o_col[i]), last_c);
        check_eq($sformatf("hold_count[%0d]", i), 32'(o_count[i]), last_cnt);
        check_eq($sformatf("hold_px[%0d]", i), 32'(o_px[i]), 32'(last_px[i]));
      end
    end
    if (ev) begin
      last_r   = q[0].r;
      last_c   = q[0].c;
      last_cnt = q[0].cnt;
      for (int i = 0; i < NI; i++) last_px[i] = q[0].px[i];
      void'(q.pop_front());
    end
  end

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_eq({tag, "_valid"}, 32'(o_valid[i]), 0);
      check_eq({tag, "_row"}, 32'(o_row[i]), 0);
      check_eq({tag, "_col"}, 32'(o_col[i]), 0);
      check_eq({tag, "_count"}, 32'(o_count[i]), 0);
      check_eq({tag, "_px"}, 32'(o_px[i]), 0);
    end
  endtask

  // Rows 0/1 have no valid line-buffer data above them, so those taps get random junk.
  task automatic drive_sample(input int r, input int c, input bit v);
    bit   inr;
    exp_t e;
    @(negedge clk);
    inr      = (r < H) && (c < W);
    in_valid = v;
    col      = CW'(c);
    row      = RW'(r);
    px_cur   = inr ? img[r][c] : 1'($urandom_range(1));
    px_up1   = (inr && r >= 1) ? img[r - 1][c] : 1'($urandom_range(1));
    px_up2   = (inr && r >= 2) ? img[r - 2][c] : 1'($urandom_range(1));
    if (v && inr && r >= 1 && c >= 1) begin
      e.r   = r - 1;
      e.c   = c - 1;
      e.cnt = win_count(r - 1, c - 1);
      for (int i = 0; i < NI; i++) e.px[i] = (e.cnt >= thr[i]);
      e.due = cyc + 3;
      q.push_back(e);
    end
  endtask

  task automatic bubble();
    drive_sample($urandom_range(H - 1), $urandom_range(W - 1), 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle; in-flight results are dropped.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst");
    q.delete();
    last_r   = 0;
    last_c   = 0;
    last_cnt = 0;
    for (int i = 0; i < NI; i++) last_px[i] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    reset_n = 1'b1;
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = 1'b1;
          1:       img[r][c] = (r == 3 && c == 3);
          2:       img[r][c] = (c == 7 && r >= 1 && r <= 3);
          default: img[r][c] = 1'($urandom_range(1));
        endcase
  endtask

  task automatic run_frame(input int bubble_pct, input bit oor, input int rst_row,
                           input int rst_col);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        while (int'($urandom_range(99)) < bubble_pct) bubble();
        if (oor && $urandom_range(4) == 0) begin
          if ($urandom_range(1) == 1) drive_sample(r, W + int'($urandom_range(3)), 1'b1);
          else drive_sample(H, c, 1'b1);
        end
        drive_sample(r, c, 1'b1);
        if (r == rst_row && c == rst_col) begin
          do_reset();
          return;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d entries pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) last_px[i] = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_all_zero("por");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    fill(0);  run_frame(0, 1'b0, -1, -1);   // all ones
    fill(1);  run_frame(0, 1'b0, -1, -1);   // single one at (3,3)
    fill(2);  run_frame(0, 1'b0, -1, -1);   // ones at col 7, rows 1..3
    fill(3);  run_frame(0, 1'b0, -1, -1);   // random, gapless
    run_frame(30, 1'b1, -1, -1);            // same frame with bubbles and out-of-range samples
    fill(3);  run_frame(20, 1'b0, 3, 4);    // reset mid row 3
    fill(3);  run_frame(10, 1'b1, -1, -1);  // fresh frame after reset

    repeat (6) bubble();
    check_eq("drain", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
